cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result FIFOs arbitrated round-robin onto N_CDB broadcast ports (optional macro CDB_BYPASS_EN).
// Latency: 1 cycle from FIFO entry to registered CDB; with CDB_BYPASS_EN an input at an empty FIFO may broadcast in the same cycle.
// Backpressure: ex_stall[i] is FIFO i full, derived from state only; flush drops inputs and empties every FIFO.
module cdb_arbiter #(
    parameter int N_EXEC     = 4,
    parameter int N_CDB      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_W      = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [N_EXEC-1:0]            ex_valid,
    input  logic [N_EXEC-1:0][ROB_W-1:0] ex_rob_id,
    input  logic [N_EXEC-1:0][31:0]      ex_rd_data,
    output logic [N_EXEC-1:0]            ex_stall,
    output logic [N_CDB-1:0]             cdb_valid,
    output logic [N_CDB-1:0][ROB_W-1:0]  cdb_rob_id,
    output logic [N_CDB-1:0][31:0]       cdb_rd_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (N_EXEC > 1) ? $clog2(N_EXEC) : 1;

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [31:0]      data;
    } entry_t;

    entry_t                       mem_q [N_EXEC][FIFO_DEPTH];
    logic [N_EXEC-1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N_EXEC-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [RR_W-1:0]              rr_q, rr_d;
    logic [N_CDB-1:0]             cdb_vld_q, cdb_vld_d;
    entry_t [N_CDB-1:0]           cdb_q, cdb_d;
    logic [N_EXEC-1:0]            enq, fifo_gnt, byp_gnt;
`ifdef CDB_BYPASS_EN
    logic [N_CDB-1:0]             byp_vld;
    entry_t [N_CDB-1:0]           byp_ent;
`endif

    always_comb begin
        for (int i = 0; i < N_EXEC; i++) begin
            ex_stall[i] = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
        end
    end

    // Round-robin scan from rr_q; FIFO grants pack into the next-cycle ports from port 0.
    always_comb begin
        int              n_grant;
        int              n_fifo;
        int              last;
        logic            gnt_any;
        logic [RR_W-1:0] idx;
`ifdef CDB_BYPASS_EN
        int              n_reg;
        int              n_byp;
`endif
        n_grant   = 0;
        n_fifo    = 0;
        last      = 0;
        gnt_any   = 1'b0;
        idx       = '0;
        fifo_gnt  = '0;
        byp_gnt   = '0;
        cdb_vld_d = '0;
        cdb_d     = '0;
`ifdef CDB_BYPASS_EN
        n_reg   = 0;
        n_byp   = 0;
        byp_vld = '0;
        byp_ent = '0;
        for (int p = 0; p < N_CDB; p++) begin
            n_reg = n_reg + int'(cdb_vld_q[p]);
        end
`endif
        for (int k = 0; k < N_EXEC; k++) begin
            idx = RR_W'((int'(rr_q) + k) % N_EXEC);
            if (!flush && n_grant < N_CDB) begin
                if (cnt_q[idx] != '0) begin
                    fifo_gnt[idx] = 1'b1;
                    for (int p = 0; p < N_CDB; p++) begin
                        if (p == n_fifo) begin
                            cdb_vld_d[p] = 1'b1;
                            cdb_d[p]     = mem_q[idx][rd_ptr_q[idx]];
                        end
                    end
                    n_fifo  = n_fifo + 1;
                    n_grant = n_grant + 1;
                    last    = int'(idx);
                    gnt_any = 1'b1;
                end
`ifdef CDB_BYPASS_EN
                // Bypass may only use ports not already carrying last cycle's registered grants.
                else if (ex_valid[idx] && n_byp < N_CDB - n_reg) begin
                    byp_gnt[idx] = 1'b1;
                    for (int p = 0; p < N_CDB; p++) begin
                        if (p == n_reg + n_byp) begin
                            byp_vld[p] = 1'b1;
                            byp_ent[p] = {ex_rob_id[idx], ex_rd_data[idx]};
                        end
                    end
                    n_byp   = n_byp + 1;
                    n_grant = n_grant + 1;
                    last    = int'(idx);
                    gnt_any = 1'b1;
                end
`endif
            end
        end
        rr_d = gnt_any ? RR_W'((last + 1) % N_EXEC) : rr_q;
    end

    always_comb begin
        for (int i = 0; i < N_EXEC; i++) begin
            enq[i]      = ex_valid[i] && !ex_stall[i] && !flush && !byp_gnt[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(enq[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(fifo_gnt[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(enq[i]) - CNT_W'(fifo_gnt[i]);
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_CDB; p++) begin
            cdb_valid[p]   = cdb_vld_q[p];
            cdb_rob_id[p]  = cdb_q[p].rob;
            cdb_rd_data[p] = cdb_q[p].data;
`ifdef CDB_BYPASS_EN
            if (byp_vld[p]) begin
                cdb_valid[p]   = 1'b1;
                cdb_rob_id[p]  = byp_ent[p].rob;
                cdb_rd_data[p] = byp_ent[p].data;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            cdb_vld_q <= '0;
            cdb_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_q     <= cdb_d;
        end
    end

    // Storage is not reset: cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_EXEC; i++) begin
            if (enq[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {ex_rob_id[i], ex_rd_data[i]};
            end
        end
    end
endmodule
